alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, handshaked successor to the datapath ALU. It registers its result and keeps architectural carry/zero flags internally, so the pipeline no longer has to capture them. It adds a multi-cycle shift-add multiply beside the single-cycle ADD/NAND/EQ operations. The block sits in the execute stage, with valid/ready on both sides so it can stall the decode stage and be stalled by writeback.

## Interface
- WIDTH, 16, operand/result width in bits (≥4).
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  block can accept an operation this cycle.
- alu_op  input  2  00 ADD, 01 NAND, 10 EQ, 11 MUL.
- cz_mod  input  2  bit1 enables carry-flag update, bit0 enables zero-flag update.
- in1, in2  input  WIDTH  operands.
- out_valid  output  1  alu_out holds a result.
- out_ready  input  1  consumer takes result.
- alu_out  output  WIDTH  registered result.
- c_flag, z_flag  output  1  architectural flags, registered.
- busy  output  1  multiply in progress.

## Operation
- Accept when in_valid && in_ready. Operands, alu_op and cz_mod are captured at acceptance. Later input changes have no effect.
- in_ready = (state==IDLE) && (!out_valid || out_ready), so a new operation may be accepted in the same cycle a result is consumed.
- States:
  - IDLE: waiting for an operation.
  - MUL: iterating; count runs 0..WIDTH-1.
- Transitions:
  - IDLE→MUL on accepted op 11, only when ALU_MUL_EN is defined.
  - MUL→IDLE on count==WIDTH-1, at which point the result is written.
  - Every other accepted op stays in IDLE and writes its result at the acceptance edge.
- Results:
  - ADD: {carry, sum} = in1+in2 at WIDTH+1 bits. alu_out = sum.
  - NAND: alu_out = ~(in1&in2).
  - EQ: alu_out = 1 if in1==in2, else 0.
  - MUL: alu_out = low WIDTH bits of the unsigned product. Carry = OR of the high WIDTH bits (overflow).
- Flag update happens at the result-write edge:
  - c_flag: loaded with carry only when cz_mod[1] && op∈{ADD,MUL}. Otherwise unchanged.
  - z_flag: loaded with (alu_out==0) only when cz_mod[0]. Otherwise unchanged.
- Output register:
  - out_valid sets at the result-write edge.
  - out_valid clears at an edge where out_ready && out_valid, unless a new result is written at that same edge, in which case it stays set.
  - alu_out is held stable while out_valid && !out_ready.
- busy = (state==MUL).
- Multiply is shift-add: one partial-product step per cycle into a 2·WIDTH accumulator, LSB-first over in2.

## Timing
- Reset values: alu_out=0, c_flag=0, z_flag=0, out_valid=0, busy=0, state IDLE, count=0. in_ready=1 the cycle after reset deasserts.
- ADD/NAND/EQ latency is 1 cycle: result and flags are visible the cycle after the acceptance edge. Throughput is 1 op/cycle when out_ready is held high.
- MUL latency is WIDTH cycles from the acceptance edge to out_valid. in_ready stays 0 throughout.
- Reset asserted mid-MUL aborts the multiply: no result and no flag update. All registers take reset values at that edge.
- Reset has priority over acceptance and over consumption at the same edge.
- Back-pressure: while out_valid && !out_ready, in_ready=0. No op is accepted and flags do not change.
- in_valid with in_ready=0 has no effect. Upstream holds the operation.

## Configuration
- ALU_MUL_EN defined: MUL datapath, counter and MUL state are compiled in, as described above.
- ALU_MUL_EN undefined:
  - op 11 is accepted with latency 1, and alu_out = 0.
  - c_flag and z_flag are unchanged regardless of cz_mod.
  - busy is tied to 0.
  - No accumulator is present.

## Test plan
- Reset, then ADD 0xFFFF+0x0001 with cz_mod=11 → next cycle alu_out=0x0000, c_flag=1, z_flag=1, out_valid=1.
- NAND 0xFFFF,0xFFFF with cz_mod=11, c_flag previously 1 → alu_out=0x0000, z_flag=1, c_flag stays 1. Then EQ 0x1234,0x1234 with cz_mod=00 → alu_out=0x0001, flags unchanged.
- Back-to-back ADDs with out_ready=1 → one result per cycle and in_ready constantly 1. Drop out_ready for 3 cycles → alu_out held, in_ready=0, no flag change.
- With ALU_MUL_EN, MUL 0x0100×0x0100 with cz_mod=11 → busy for 16 cycles, then alu_out=0x0000, c_flag=1, z_flag=1. MUL 0x0003×0x0005 → alu_out=0x000F, c_flag=0.
- Assert reset 5 cycles into a MUL → out_valid never rises, flags=0, in_ready=1 the cycle after reset deasserts.
- Without ALU_MUL_EN, op 11 with cz_mod=11 and flags at 1 → latency 1, alu_out=0x0000, flags stay 1, busy=0.

Source files
------------

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe
//  Description : Execute-stage ALU with valid/ready handshakes on both sides.
//                Single-cycle ADD / NAND / EQ, optional multi-cycle shift-add
//                multiply, registered result and architectural carry/zero
//                flags held inside the block.
//
//  Optional feature macro:
//      ALU_MUL_EN  - when defined, compiles in the multiply state, counter
//                    and 2*WIDTH accumulator. When undefined, op 11 completes
//                    in one cycle with a zero result, leaves the flags alone,
//                    and busy is tied low.
//
//  Ports:
//      clk        in   clock, all state changes on the rising edge
//      reset      in   synchronous active-high reset
//      in_valid   in   operation presented
//      in_ready   out  operation can be accepted this cycle
//      alu_op     in   00 ADD, 01 NAND, 10 EQ, 11 MUL
//      cz_mod     in   bit1 enables carry update, bit0 enables zero update
//      in1, in2   in   operands (WIDTH bits)
//      out_valid  out  alu_out holds a result
//      out_ready  in   consumer takes the result
//      alu_out    out  registered result (WIDTH bits)
//      c_flag     out  architectural carry flag
//      z_flag     out  architectural zero flag
//      busy       out  multiply in progress
//
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [1:0]       cz_mod,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             c_flag,
    output logic             z_flag,
    output logic             busy
);

    localparam logic [1:0] c_OP_ADD  = 2'b00;
    localparam logic [1:0] c_OP_NAND = 2'b01;
    localparam logic [1:0] c_OP_EQ   = 2'b10;
    localparam logic [1:0] c_OP_MUL  = 2'b11;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_alu_out;
    logic               r_out_valid;
    logic               r_c_flag;
    logic               r_z_flag;

    logic               w_accept;
    logic [WIDTH:0]     w_sum;
    logic               w_wr_en;
    logic [WIDTH-1:0]   w_wr_data;
    logic               w_wr_carry;
    logic               w_wr_c_en;
    logic               w_wr_z_en;
    logic               w_wr_zero;

`ifdef ALU_MUL_EN
    localparam int              c_CW       = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(WIDTH - 1);

    logic [c_CW-1:0]    r_count;
    logic [2*WIDTH-1:0] r_mcand;     // in1, shifted left one place per step
    logic [WIDTH-1:0]   r_mplier;    // in2, shifted right so bit 0 is the current bit
    logic [2*WIDTH-1:0] r_acc;
    logic [1:0]         r_mul_cz;
    logic [2*WIDTH-1:0] w_acc_next;
    logic               w_mul_last;
    logic               w_mul_start;

    assign w_acc_next  = r_acc + (r_mplier[0] ? r_mcand : {(2*WIDTH){1'b0}});
    assign w_mul_last  = (r_state == S_MUL) && (r_count == c_CNT_LAST);
    assign w_mul_start = w_accept && (alu_op == c_OP_MUL);
`endif

    // A result being consumed frees the output register for a new one at the
    // same edge, so readiness looks at out_ready combinationally.
    assign in_ready  = (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_sum     = {1'b0, in1} + {1'b0, in2};

    assign out_valid = r_out_valid;
    assign alu_out   = r_alu_out;
    assign c_flag    = r_c_flag;
    assign z_flag    = r_z_flag;

`ifdef ALU_MUL_EN
    assign busy = (r_state == S_MUL);
`else
    assign busy = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
`ifdef ALU_MUL_EN
                if (w_mul_start) begin
                    w_state_next = S_MUL;
                end
`endif
            end
            S_MUL: begin
`ifdef ALU_MUL_EN
                if (w_mul_last) begin
                    w_state_next = S_IDLE;
                end
`else
                w_state_next = S_IDLE;
`endif
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Result-write selection: a single-cycle op at its acceptance edge, or
    // the final multiply step.
    // ------------------------------------------------------------------
    always_comb begin
        w_wr_en    = 1'b0;
        w_wr_data  = '0;
        w_wr_carry = w_sum[WIDTH];
        w_wr_c_en  = 1'b0;
        w_wr_z_en  = 1'b0;

        if (w_accept) begin
            case (alu_op)
                c_OP_ADD: begin
                    w_wr_en   = 1'b1;
                    w_wr_data = w_sum[WIDTH-1:0];
                    w_wr_c_en = cz_mod[1];
                    w_wr_z_en = cz_mod[0];
                end
                c_OP_NAND: begin
                    w_wr_en   = 1'b1;
                    w_wr_data = ~(in1 & in2);
                    w_wr_z_en = cz_mod[0];
                end
                c_OP_EQ: begin
                    w_wr_en   = 1'b1;
                    w_wr_data = {{(WIDTH-1){1'b0}}, (in1 == in2)};
                    w_wr_z_en = cz_mod[0];
                end
                default: begin
`ifndef ALU_MUL_EN
                    // Multiply not built: complete at once with zero and
                    // leave both flags untouched.
                    w_wr_en   = 1'b1;
                    w_wr_data = '0;
`endif
                end
            endcase
        end

`ifdef ALU_MUL_EN
        if (w_mul_last) begin
            w_wr_en    = 1'b1;
            w_wr_data  = w_acc_next[WIDTH-1:0];
            w_wr_carry = |w_acc_next[2*WIDTH-1:WIDTH];
            w_wr_c_en  = r_mul_cz[1];
            w_wr_z_en  = r_mul_cz[0];
        end
`endif
    end

    assign w_wr_zero = (w_wr_data == '0);

    // ------------------------------------------------------------------
    // Output register and flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu_out   <= '0;
            r_out_valid <= 1'b0;
            r_c_flag    <= 1'b0;
            r_z_flag    <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_alu_out   <= w_wr_data;
                r_out_valid <= 1'b1;
                if (w_wr_c_en) begin
                    r_c_flag <= w_wr_carry;
                end
                if (w_wr_z_en) begin
                    r_z_flag <= w_wr_zero;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_MUL_EN
    // ------------------------------------------------------------------
    // Shift-add multiplier: one partial product per cycle, LSB of in2 first.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_mul_cz <= 2'b00;
        end else if (w_mul_start) begin
            r_count  <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, in1};
            r_mplier <= in2;
            r_acc    <= '0;
            r_mul_cz <= cz_mod;
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= w_mul_last ? '0 : r_count + c_CW'(1);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_pipe
//  Description : Directed self-checking bench for alu_pipe (WIDTH = 16).
//                Expected values are hand-computed constants. The multiply
//                section follows whichever way ALU_MUL_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

    localparam int WIDTH = 16;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_op;
    logic [1:0]       cz_mod;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_out;
    logic             c_flag;
    logic             z_flag;
    logic             busy;

    int n_assert;
    int n_fail;

    alu_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .cz_mod    (cz_mod),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .c_flag    (c_flag),
        .z_flag    (z_flag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [1:0] cz,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        in_valid = 1'b1;
        alu_op   = op;
        cz_mod   = cz;
        in1      = a;
        in2      = b;
    endtask

    task automatic chk_res(input string tag, input logic [WIDTH-1:0] res,
                           input logic c, input logic z);
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_out"},   alu_out,   res);
        chk({tag, "_c"},     c_flag,    c);
        chk({tag, "_z"},     z_flag,    z);
    endtask

`ifdef ALU_MUL_EN
    // Presents a multiply, then checks busy/out_valid across its WIDTH cycles.
    task automatic mul_run(input string tag, input logic [1:0] cz,
                           input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] res, input logic c, input logic z);
        drive(2'b11, cz, a, b);
        tick();
        in_valid = 1'b0;
        chk({tag, "_busy0"},  busy,     1'b1);
        chk({tag, "_ready0"}, in_ready, 1'b0);
        for (int i = 1; i < WIDTH; i++) begin
            chk({tag, "_pend"}, out_valid, 1'b0);
            tick();
        end
        chk({tag, "_pend_last"}, out_valid, 1'b0);
        tick();
        chk_res(tag, res, c, z);
        chk({tag, "_busy_end"}, busy, 1'b0);
    endtask
`endif

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        alu_op    = 2'b00;
        cz_mod    = 2'b00;
        in1       = '0;
        in2       = '0;
        out_ready = 1'b1;

        // Reset
        tick();
        tick();
        chk("rst_out",   alu_out,   16'h0000);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_c",     c_flag,    1'b0);
        chk("rst_z",     z_flag,    1'b0);
        chk("rst_busy",  busy,      1'b0);
        reset = 1'b0;
        tick();
        chk("rst_ready", in_ready, 1'b1);

        // ADD with carry-out and zero result
        drive(2'b00, 2'b11, 16'hFFFF, 16'h0001);
        tick();
        chk_res("add_wrap", 16'h0000, 1'b1, 1'b1);

        // NAND, zero result, carry untouched
        drive(2'b01, 2'b11, 16'hFFFF, 16'hFFFF);
        tick();
        chk_res("nand_zero", 16'h0000, 1'b1, 1'b1);

        drive(2'b01, 2'b01, 16'h00FF, 16'h0F0F);
        tick();
        chk_res("nand_mix", 16'hFFF0, 1'b1, 1'b0);

        // EQ, flags not enabled
        drive(2'b10, 2'b00, 16'h1234, 16'h1234);
        tick();
        chk_res("eq_true", 16'h0001, 1'b1, 1'b0);

        drive(2'b10, 2'b01, 16'h1234, 16'h1235);
        tick();
        chk_res("eq_false", 16'h0000, 1'b1, 1'b1);

        // Back-to-back ADDs, one result per cycle
        drive(2'b00, 2'b10, 16'h1000, 16'h0234);
        tick();
        chk_res("b2b_1", 16'h1234, 1'b0, 1'b1);
        chk("b2b_1_ready", in_ready, 1'b1);

        drive(2'b00, 2'b10, 16'h8000, 16'h8001);
        tick();
        chk_res("b2b_2", 16'h0001, 1'b1, 1'b1);
        chk("b2b_2_ready", in_ready, 1'b1);

        drive(2'b00, 2'b00, 16'h7FFF, 16'h0001);
        tick();
        chk_res("b2b_3", 16'h8000, 1'b1, 1'b1);
        chk("b2b_3_ready", in_ready, 1'b1);

        drive(2'b00, 2'b11, 16'h0002, 16'h0003);
        tick();
        chk_res("b2b_4", 16'h0005, 1'b0, 1'b0);

        // Back-pressure: pending op must not be taken, result and flags held
        out_ready = 1'b0;
        drive(2'b00, 2'b11, 16'hFFFF, 16'h0001);
        #1;
        chk("bp_ready_now", in_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_res("bp_hold", 16'h0005, 1'b0, 1'b0);
            chk("bp_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1'b1);
        tick();
        chk_res("bp_release", 16'h0000, 1'b1, 1'b1);

        // Drain
        in_valid = 1'b0;
        tick();
        chk("drain_valid", out_valid, 1'b0);
        chk("drain_out",   alu_out,   16'h0000);

`ifdef ALU_MUL_EN
        // Clear flags so the multiply's flag writes are visible
        drive(2'b00, 2'b11, 16'h0001, 16'h0001);
        tick();
        chk_res("pre_mul", 16'h0002, 1'b0, 1'b0);
        in_valid = 1'b0;
        tick();

        mul_run("mul_ovf", 2'b11, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1);
        tick();
        mul_run("mul_3x5", 2'b11, 16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0);
        tick();

        // Set flags, then abort a multiply with reset
        drive(2'b00, 2'b11, 16'hFFFF, 16'h0001);
        tick();
        chk_res("pre_abort", 16'h0000, 1'b1, 1'b1);
        drive(2'b11, 2'b11, 16'h0003, 16'h0005);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("abort_busy", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_valid", out_valid, 1'b0);
        chk("abort_c",     c_flag,    1'b0);
        chk("abort_z",     z_flag,    1'b0);
        chk("abort_busy0", busy,      1'b0);
        tick();
        chk("abort_ready", in_ready, 1'b1);
        for (int i = 0; i < WIDTH + 4; i++) begin
            tick();
            chk("abort_never_valid", out_valid, 1'b0);
        end
`else
        // op 11 without multiplier: one cycle, zero result, flags held at 1
        drive(2'b11, 2'b11, 16'h1234, 16'h0002);
        #1;
        chk("mul_off_ready", in_ready, 1'b1);
        tick();
        chk_res("mul_off", 16'h0000, 1'b1, 1'b1);
        chk("mul_off_busy", busy, 1'b0);

        drive(2'b11, 2'b11, 16'h0003, 16'h0005);
        tick();
        chk_res("mul_off2", 16'h0000, 1'b1, 1'b1);

        // Reset wins over acceptance at the same edge
        drive(2'b00, 2'b11, 16'h0001, 16'h0001);
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("rst_prio_valid", out_valid, 1'b0);
        chk("rst_prio_out",   alu_out,   16'h0000);
        chk("rst_prio_c",     c_flag,    1'b0);
        chk("rst_prio_z",     z_flag,    1'b0);
        tick();
        chk("rst_prio_ready", in_ready, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
